fm_sb_capture_ctrl: RTL and testbench
=====================================

Name: fm_sb_capture_ctrl

Overview:
Capture/freeze scheduler for the floating-monitor spy-buffer bank: one controller sequences all SB_N spy buffers (3 stations x 3 threads x {slc, hit, ptcalc} = 27).
- Drives a common ring-buffer write address and per-buffer write enables from the fm_rt valid bits.
- Handles arm, trigger, post-trigger count and freeze, and writes trigger metadata.
- Sequences playback reads.
- Sits between the fm_rt taps and the SB_MEM/SB_META memories; arm, release and mode come from FM_CTRL.

Parameters:
- SB_N, 27, number of spy buffers controlled
- ADDR_W, 10, spy-buffer memory address width (depth 2**ADDR_W)
- PB_MODE_W, 2, playback-mode field width

Ports:
- spy_clock  in  1  spy-buffer clock
- rst  in  1  asynchronous active-high reset
- arm_i  in  1  single-cycle arm/start pulse
- freeze_release_i  in  1  single-cycle release pulse; leave FROZEN or stop PLAY
- force_trig_i  in  1  software trigger
- ext_trig_i  in  1  external trigger
- trig_mask_i  in  SB_N  buffers whose fm_vld may trigger
- post_trig_len_i  in  ADDR_W  writes after trigger before freeze
- pb_mode_i  in  PB_MODE_W  0 capture, 1 playback-once, 2 playback-loop, 3 treated as 0
- fm_vld_i  in  SB_N  per-buffer fm_vld
- sb_we_o  out  SB_N  per-buffer write enable
- sb_waddr_o  out  ADDR_W  common write address
- meta_we_o  out  1  SB_META write strobe
- meta_trig_addr_o  out  ADDR_W  write address at trigger
- pb_vld_o  out  1  playback read valid
- pb_raddr_o  out  ADDR_W  playback read address
- frozen_o  out  1  high in FROZEN
- state_o  out  3  IDLE=0 ARMED=1 POST=2 FROZEN=3 PLAY=4
- trig_cnt_o  out  16  accepted-trigger count (optional feature)

Behaviour:
- Reset (async, any state): state IDLE; all outputs 0; internal counters 0.
- All outputs registered. sb_we_o and sb_waddr_o lag fm_vld_i by 1 cycle, so the datapath delays fm_data by 1 cycle.
- IDLE:
  - arm_i with pb_mode_i in {0,3}: go to ARMED, waddr<=0.
  - arm_i with pb_mode_i in {1,2}: go to PLAY, raddr<=0.
- ARMED:
  - Each cycle: sb_we_o<=fm_vld_i; waddr increments every cycle regardless of valids, keeping buffers time-aligned. Wrap 2**ADDR_W-1 -> 0.
  - trig = force_trig_i | ext_trig_i | |(fm_vld_i & trig_mask_i).
  - On trig: meta_trig_addr_o <= address written this cycle; meta_we_o pulses 1 cycle; cnt<=post_trig_len_i.
  - Next state is POST, or FROZEN if post_trig_len_i==0. The trigger-cycle write is still performed.
- POST:
  - Writes continue; cnt decrements per cycle.
  - After exactly post_trig_len_i further writes go to FROZEN.
  - Further triggers ignored, no meta write. post_trig_len_i is sampled only at trigger.
- FROZEN:
  - sb_we_o=0; frozen_o=1; waddr holds.
  - freeze_release_i goes to IDLE. arm_i is ignored.
- PLAY:
  - pb_vld_o=1; pb_raddr_o increments 0..2**ADDR_W-1.
  - Mode 1: after the last address, go to IDLE with pb_vld_o=0.
  - Mode 2: wrap to 0 and continue.
  - freeze_release_i in PLAY: go to IDLE next cycle. pb_mode_i is sampled at arm only.
- Simultaneous events:
  - arm_i in ARMED/POST/PLAY: ignored.
  - freeze_release_i in ARMED/POST: aborts to IDLE with no freeze; a meta write already issued stands.
  - freeze_release_i with trig in ARMED: release wins.
- post_trig_len_i >= 2**ADDR_W: impossible by width. post_trig_len_i = 2**ADDR_W-1 overwrites all but the trigger entry.

Optional Feature:
FM_SB_TRIG_CNT_EN
- Defined: trig_cnt_o increments on every accepted trigger (ARMED -> POST/FROZEN). It saturates at 0xFFFF, clears only on rst, and is unaffected by release.
- Undefined: no counter logic; trig_cnt_o is tied to 0.

Test Plan:
- rst mid-POST (cnt=5) -> state_o=0, sb_we_o=0, frozen_o=0, meta_we_o=0 on the same cycle (async).
- arm with pb_mode 0, fm_vld_i=all-1s, trig_mask_i=0, force_trig_i at waddr 100, post_trig_len_i=10 -> meta_we_o once with meta_trig_addr_o=100; last write at 110; FROZEN; sb_waddr_o holds 110.
- ADDR_W=4, trigger at waddr 14, post_trig_len_i=3 -> writes 15,0,1 then FROZEN; meta_trig_addr_o=14.
- trig_mask_i bit 9 set, fm_vld_i[9] rises while ARMED -> trigger; second fm_vld_i[9] pulse in POST -> no second meta_we_o; trig_cnt_o=1 (macro on).
- post_trig_len_i=0 with ext_trig_i -> FROZEN the next cycle after exactly one write; freeze_release_i -> IDLE; a following arm_i re-arms with waddr 0.
- pb_mode 1, ADDR_W=4 -> pb_vld_o for 16 cycles with raddr 0..15, then IDLE. pb_mode 2 -> raddr wraps 15->0; freeze_release_i at raddr 7 -> pb_vld_o=0 the next cycle.

Source files
------------

// File: rtl/fm_sb_capture_ctrl.sv
// Capture/freeze scheduler for the floating-monitor spy-buffer bank: ring write
// addressing, trigger/post-trigger/freeze sequencing, metadata strobe and playback reads.
// Optional accepted-trigger counter enabled by defining FM_SB_TRIG_CNT_EN.
module fm_sb_capture_ctrl #(
    parameter int unsigned SB_N      = 27,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned PB_MODE_W = 2
) (
    input  logic                 spy_clock,
    input  logic                 rst,
    input  logic                 arm_i,
    input  logic                 freeze_release_i,
    input  logic                 force_trig_i,
    input  logic                 ext_trig_i,
    input  logic [SB_N-1:0]      trig_mask_i,
    input  logic [ADDR_W-1:0]    post_trig_len_i,
    input  logic [PB_MODE_W-1:0] pb_mode_i,
    input  logic [SB_N-1:0]      fm_vld_i,
    output logic [SB_N-1:0]      sb_we_o,
    output logic [ADDR_W-1:0]    sb_waddr_o,
    output logic                 meta_we_o,
    output logic [ADDR_W-1:0]    meta_trig_addr_o,
    output logic                 pb_vld_o,
    output logic [ADDR_W-1:0]    pb_raddr_o,
    output logic                 frozen_o,
    output logic [2:0]           state_o,
    output logic [15:0]          trig_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARMED  = 3'd1,
        S_POST   = 3'd2,
        S_FROZEN = 3'd3,
        S_PLAY   = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    state_t            state;
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] cnt;
    logic              pb_loop;
    logic              trig;
    logic              play_req;
    logic              loop_req;

    assign trig     = force_trig_i | ext_trig_i | (|(fm_vld_i & trig_mask_i));
    assign play_req = (pb_mode_i == PB_MODE_W'(1)) || (pb_mode_i == PB_MODE_W'(2));
    assign loop_req = (pb_mode_i == PB_MODE_W'(2));
    assign state_o  = state;

    always_ff @(posedge spy_clock or posedge rst) begin
        if (rst) begin
            state            <= S_IDLE;
            wptr             <= '0;
            cnt              <= '0;
            pb_loop          <= 1'b0;
            sb_we_o          <= '0;
            sb_waddr_o       <= '0;
            meta_we_o        <= 1'b0;
            meta_trig_addr_o <= '0;
            pb_vld_o         <= 1'b0;
            pb_raddr_o       <= '0;
            frozen_o         <= 1'b0;
        end else begin
            meta_we_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    sb_we_o  <= '0;
                    pb_vld_o <= 1'b0;
                    frozen_o <= 1'b0;
                    if (arm_i) begin
                        if (play_req) begin
                            state      <= S_PLAY;
                            pb_vld_o   <= 1'b1;
                            pb_raddr_o <= '0;
                            pb_loop    <= loop_req;
                        end else begin
                            state <= S_ARMED;
                            wptr  <= '0;
                        end
                    end
                end
                S_ARMED: begin
                    // Release takes priority over a same-cycle trigger and suppresses the write.
                    if (freeze_release_i) begin
                        state   <= S_IDLE;
                        sb_we_o <= '0;
                    end else begin
                        sb_we_o    <= fm_vld_i;
                        sb_waddr_o <= wptr;
                        wptr       <= wptr + ADDR_W'(1);
                        if (trig) begin
                            meta_we_o        <= 1'b1;
                            meta_trig_addr_o <= wptr;
                            cnt              <= post_trig_len_i;
                            if (post_trig_len_i == '0) begin
                                state    <= S_FROZEN;
                                frozen_o <= 1'b1;
                            end else begin
                                state <= S_POST;
                            end
                        end
                    end
                end
                S_POST: begin
                    if (freeze_release_i) begin
                        state   <= S_IDLE;
                        sb_we_o <= '0;
                    end else begin
                        sb_we_o    <= fm_vld_i;
                        sb_waddr_o <= wptr;
                        wptr       <= wptr + ADDR_W'(1);
                        cnt        <= cnt - ADDR_W'(1);
                        if (cnt == ADDR_W'(1)) begin
                            state    <= S_FROZEN;
                            frozen_o <= 1'b1;
                        end
                    end
                end
                S_FROZEN: begin
                    sb_we_o <= '0;
                    if (freeze_release_i) begin
                        state    <= S_IDLE;
                        frozen_o <= 1'b0;
                    end
                end
                S_PLAY: begin
                    if (freeze_release_i || (pb_raddr_o == ADDR_MAX && !pb_loop)) begin
                        state    <= S_IDLE;
                        pb_vld_o <= 1'b0;
                    end else begin
                        pb_raddr_o <= pb_raddr_o + ADDR_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef FM_SB_TRIG_CNT_EN
    logic [15:0] trig_cnt;

    always_ff @(posedge spy_clock or posedge rst) begin
        if (rst) begin
            trig_cnt <= '0;
        end else if (state == S_ARMED && !freeze_release_i && trig && trig_cnt != '1) begin
            trig_cnt <= trig_cnt + 16'd1;
        end
    end

    assign trig_cnt_o = trig_cnt;
`else
    assign trig_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fm_sb_capture_ctrl.sv
// Directed self-checking bench for fm_sb_capture_ctrl; drives a default-width
// instance and an ADDR_W=4 instance from the same stimulus.
module tb_fm_sb_capture_ctrl;

    localparam int unsigned SB_N = 27;

    logic            spy_clock = 1'b0;
    logic            rst;
    logic            arm_i, freeze_release_i, force_trig_i, ext_trig_i;
    logic [SB_N-1:0] trig_mask_i, fm_vld_i;
    logic [9:0]      post_trig_len_i;
    logic [1:0]      pb_mode_i;

    logic [SB_N-1:0] b_we, s_we;
    logic [9:0]      b_waddr, b_meta_addr, b_raddr;
    logic [3:0]      s_waddr, s_meta_addr, s_raddr;
    logic            b_meta_we, b_pb_vld, b_frozen, s_meta_we, s_pb_vld, s_frozen;
    logic [2:0]      b_state, s_state;
    logic [15:0]     b_tcnt, s_tcnt;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned meta_cnt;
    logic [SB_N-1:0] ones = '1;
    logic [SB_N-1:0] bit9;
    logic [15:0]     exp_tcnt1, exp_tcnt3;

    always #5 spy_clock = ~spy_clock;

    fm_sb_capture_ctrl #(.SB_N(SB_N), .ADDR_W(10), .PB_MODE_W(2)) u_big (
        .spy_clock(spy_clock), .rst(rst), .arm_i(arm_i), .freeze_release_i(freeze_release_i),
        .force_trig_i(force_trig_i), .ext_trig_i(ext_trig_i), .trig_mask_i(trig_mask_i),
        .post_trig_len_i(post_trig_len_i), .pb_mode_i(pb_mode_i), .fm_vld_i(fm_vld_i),
        .sb_we_o(b_we), .sb_waddr_o(b_waddr), .meta_we_o(b_meta_we), .meta_trig_addr_o(b_meta_addr),
        .pb_vld_o(b_pb_vld), .pb_raddr_o(b_raddr), .frozen_o(b_frozen), .state_o(b_state),
        .trig_cnt_o(b_tcnt)
    );

    fm_sb_capture_ctrl #(.SB_N(SB_N), .ADDR_W(4), .PB_MODE_W(2)) u_small (
        .spy_clock(spy_clock), .rst(rst), .arm_i(arm_i), .freeze_release_i(freeze_release_i),
        .force_trig_i(force_trig_i), .ext_trig_i(ext_trig_i), .trig_mask_i(trig_mask_i),
        .post_trig_len_i(post_trig_len_i[3:0]), .pb_mode_i(pb_mode_i), .fm_vld_i(fm_vld_i),
        .sb_we_o(s_we), .sb_waddr_o(s_waddr), .meta_we_o(s_meta_we), .meta_trig_addr_o(s_meta_addr),
        .pb_vld_o(s_pb_vld), .pb_raddr_o(s_raddr), .frozen_o(s_frozen), .state_o(s_state),
        .trig_cnt_o(s_tcnt)
    );

    task automatic tick();
        @(posedge spy_clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        bit9 = '0;
        bit9[9] = 1'b1;
`ifdef FM_SB_TRIG_CNT_EN
        exp_tcnt1 = 16'd1;
        exp_tcnt3 = 16'd3;
`else
        exp_tcnt1 = 16'd0;
        exp_tcnt3 = 16'd0;
`endif
        rst = 1'b1; arm_i = 0; freeze_release_i = 0; force_trig_i = 0; ext_trig_i = 0;
        trig_mask_i = '0; fm_vld_i = '0; post_trig_len_i = '0; pb_mode_i = '0;
        #1;
        chk("rst_state", b_state, 0);
        chk("rst_we", b_we, 0);
        chk("rst_waddr", b_waddr, 0);
        chk("rst_meta_we", b_meta_we, 0);
        chk("rst_frozen", b_frozen, 0);
        chk("rst_pb_vld", b_pb_vld, 0);
        chk("rst_tcnt", b_tcnt, 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Capture: trigger at address 100, ten post-trigger writes
        fm_vld_i = '1; post_trig_len_i = 10'd10;
        arm_i = 1; tick(); arm_i = 0;
        chk("A_armed", b_state, 1);
        repeat (100) tick();
        chk("A_pre_waddr", b_waddr, 99);
        chk("A_pre_we", b_we, ones);
        force_trig_i = 1; tick(); force_trig_i = 0;
        chk("A_meta_we", b_meta_we, 1);
        chk("A_meta_addr", b_meta_addr, 100);
        chk("A_trig_waddr", b_waddr, 100);
        chk("A_post", b_state, 2);
        meta_cnt = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (b_meta_we) meta_cnt++;
            chk("A_post_waddr", b_waddr, 64'(100 + i));
            chk("A_post_state", b_state, (i < 10) ? 64'd2 : 64'd3);
        end
        chk("A_meta_once", meta_cnt, 0);
        chk("A_last_we", b_we, ones);
        tick();
        chk("A_frz_we", b_we, 0);
        chk("A_frz_flag", b_frozen, 1);
        chk("A_frz_waddr", b_waddr, 110);
        chk("A_frz_meta_addr", b_meta_addr, 100);
        arm_i = 1; tick(); arm_i = 0;
        chk("A_arm_ignored", b_state, 3);
        freeze_release_i = 1; tick(); freeze_release_i = 0;
        chk("A_release", b_state, 0);
        chk("A_release_frozen", b_frozen, 0);

        // Asynchronous reset in the middle of POST
        arm_i = 1; tick(); arm_i = 0;
        force_trig_i = 1; tick(); force_trig_i = 0;
        repeat (5) tick();
        chk("R_in_post", b_state, 2);
        #2 rst = 1'b1;
        #1;
        chk("R_state", b_state, 0);
        chk("R_we", b_we, 0);
        chk("R_frozen", b_frozen, 0);
        chk("R_meta_we", b_meta_we, 0);
        chk("R_small_state", s_state, 0);
        tick();
        rst = 1'b0;
        tick();

        // Masked fm_vld trigger; a second pulse in POST is ignored
        fm_vld_i = '0; trig_mask_i = bit9; post_trig_len_i = 10'd4;
        arm_i = 1; tick(); arm_i = 0;
        tick();
        fm_vld_i = bit9; tick(); fm_vld_i = '0;
        chk("M_meta_we", b_meta_we, 1);
        chk("M_meta_addr", b_meta_addr, 1);
        chk("M_we", b_we, 64'(bit9));
        chk("M_post", b_state, 2);
        tick();
        fm_vld_i = bit9; tick(); fm_vld_i = '0;
        chk("M_no_meta2", b_meta_we, 0);
        chk("M_still_post", b_state, 2);
        chk("M_tcnt", b_tcnt, exp_tcnt1);
        tick(); tick();
        chk("M_frozen", b_state, 3);
        freeze_release_i = 1; tick(); freeze_release_i = 0;
        trig_mask_i = '0;

        // ADDR_W=4: trigger at 14 wraps through 15, 0, 1
        fm_vld_i = '1; post_trig_len_i = 10'd3;
        arm_i = 1; tick(); arm_i = 0;
        repeat (14) tick();
        force_trig_i = 1; tick(); force_trig_i = 0;
        chk("W_meta_we", s_meta_we, 1);
        chk("W_meta_addr", s_meta_addr, 14);
        chk("W_waddr14", s_waddr, 14);
        tick();
        chk("W_waddr15", s_waddr, 15);
        chk("W_state15", s_state, 2);
        tick();
        chk("W_waddr0", s_waddr, 0);
        tick();
        chk("W_waddr1", s_waddr, 1);
        chk("W_frozen_state", s_state, 3);
        tick();
        chk("W_frz_we", s_we, 0);
        chk("W_frz_waddr", s_waddr, 1);
        chk("W_frz_flag", s_frozen, 1);
        freeze_release_i = 1; tick(); freeze_release_i = 0;

        // Zero post-trigger length with external trigger, then re-arm
        post_trig_len_i = 10'd0;
        arm_i = 1; tick(); arm_i = 0;
        repeat (3) tick();
        ext_trig_i = 1; tick(); ext_trig_i = 0;
        chk("Z_state", b_state, 3);
        chk("Z_waddr", b_waddr, 3);
        chk("Z_we", b_we, ones);
        chk("Z_meta_addr", b_meta_addr, 3);
        chk("Z_frozen", b_frozen, 1);
        tick();
        chk("Z_we_off", b_we, 0);
        chk("Z_waddr_hold", b_waddr, 3);
        freeze_release_i = 1; tick(); freeze_release_i = 0;
        chk("Z_idle", b_state, 0);
        arm_i = 1; tick(); arm_i = 0;
        chk("Z_rearm", b_state, 1);
        tick();
        chk("Z_rearm_waddr", b_waddr, 0);
        freeze_release_i = 1; force_trig_i = 1; tick();
        freeze_release_i = 0; force_trig_i = 0;
        chk("Z_rel_wins_state", b_state, 0);
        chk("Z_rel_wins_meta", b_meta_we, 0);
        chk("Z_tcnt", b_tcnt, exp_tcnt3);
        fm_vld_i = '0;

        // Playback once, then looping playback with release at raddr 7
        pb_mode_i = 2'd1;
        arm_i = 1; tick(); arm_i = 0;
        chk("P1_state", s_state, 4);
        chk("P1_vld0", s_pb_vld, 1);
        chk("P1_raddr0", s_raddr, 0);
        for (int i = 1; i <= 15; i++) begin
            tick();
            chk("P1_raddr", s_raddr, 64'(i));
            chk("P1_vld", s_pb_vld, 1);
        end
        tick();
        chk("P1_done_vld", s_pb_vld, 0);
        chk("P1_done_state", s_state, 0);
        pb_mode_i = 2'd2;
        arm_i = 1; tick(); arm_i = 0;
        chk("P2_raddr0", s_raddr, 0);
        chk("P2_big_arm_ignored", b_raddr, 17);
        repeat (15) tick();
        chk("P2_raddr15", s_raddr, 15);
        tick();
        chk("P2_wrap", s_raddr, 0);
        chk("P2_wrap_vld", s_pb_vld, 1);
        repeat (7) tick();
        chk("P2_raddr7", s_raddr, 7);
        freeze_release_i = 1; tick(); freeze_release_i = 0;
        chk("P2_stop_vld", s_pb_vld, 0);
        chk("P2_stop_state", s_state, 0);
        chk("P2_big_stop", b_pb_vld, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
